hms_clock_ctrl: RTL

//   Time-of-day core that feeds the six-digit display path: keeps HH:MM:SS,

---
 rtl/hms_clock_ctrl_if.sv | 11 +
 rtl/hms_clock_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/hms_clock_ctrl_if.sv
// hms_clock_ctrl_if: push-button inputs and display/mode outputs of the time-of-day core
interface hms_clock_ctrl_if;
  logic        i_sw_mode;
  logic        i_sw_inc;
  logic [23:0] o_bcd_digits;
  logic [5:0]  o_six_dp;
  logic [1:0]  o_mode;
  logic        o_sec_tick;
  modport master (output i_sw_mode, i_sw_inc, input o_bcd_digits, o_six_dp, o_mode, o_sec_tick);
  modport slave (input i_sw_mode, i_sw_inc, output o_bcd_digits, o_six_dp, o_mode, o_sec_tick);
endinterface

// File: rtl/hms_clock_ctrl.sv
// hms_clock_ctrl: HH:MM:SS clock with two-button set modes, six BCD digits and blinking decimal points
module hms_clock_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input logic            clk,
  input logic            rst,
  hms_clock_ctrl_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  typedef enum logic [1:0] {RUN, SET_SEC, SET_MIN, SET_HOUR} mode_t;
  mode_t         mode;
  logic [5:0]    sec, min;
  logic [4:0]    hour;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic [1:0]    sync1, sync2, lvl, lvl_d;
  logic [DW-1:0] deb_cnt [2];
  logic          sec_tick, mode_p, inc_p, blink_end;
  assign sec_tick  = tick_cnt == TW'(TICK_DIV - 1);
  assign blink_end = blink_cnt == BW'(BLINK_DIV - 1);
  assign mode_p    = lvl[0] & ~lvl_d[0];
  assign inc_p     = lvl[1] & ~lvl_d[1];
  // bit 0 = mode button, bit 1 = inc button
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      lvl     <= '0;
      lvl_d   <= '0;
      deb_cnt <= '{default: '0};
    end else begin
      sync1 <= {bus.i_sw_inc, bus.i_sw_mode};
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++)
        if (sync2[i] == lvl[i]) deb_cnt[i] <= '0;
        else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          lvl[i]     <= sync2[i];
        end else deb_cnt[i] <= deb_cnt[i] + DW'(1);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode      <= RUN;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      tick_cnt  <= sec_tick ? '0 : tick_cnt + TW'(1);
      blink_cnt <= blink_end ? '0 : blink_cnt + BW'(1);
      if (blink_end) blink <= ~blink;
      if (mode_p) begin
        mode      <= mode_t'(mode + 2'd1);
        blink     <= 1'b0;
        blink_cnt <= '0;
        if (mode == SET_HOUR) tick_cnt <= '0;
      end else if (inc_p) begin
        if (mode == SET_SEC) sec <= sec == 6'd59 ? '0 : sec + 6'd1;
        if (mode == SET_MIN) min <= min == 6'd59 ? '0 : min + 6'd1;
        if (mode == SET_HOUR) hour <= hour == 5'd23 ? '0 : hour + 5'd1;
      end
      if (mode == RUN && sec_tick) begin
        sec <= sec == 6'd59 ? '0 : sec + 6'd1;
        if (sec == 6'd59) begin
          min <= min == 6'd59 ? '0 : min + 6'd1;
          if (min == 6'd59) hour <= hour == 5'd23 ? '0 : hour + 5'd1;
        end
      end
    end
  function automatic logic [7:0] bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction
  assign bus.o_bcd_digits = {bcd({1'b0, hour}), bcd(min), bcd(sec)};
  assign bus.o_six_dp = mode == RUN     ? 6'b010100 :
                        mode == SET_SEC ? {4'b0, {2{blink}}} :
                        mode == SET_MIN ? {2'b0, {2{blink}}, 2'b0} :
                                          {{2{blink}}, 4'b0};
  assign bus.o_mode     = mode;
  assign bus.o_sec_tick = sec_tick;
endmodule
